// File: rtl/rr_arb_mux.sv
// rr_arb_mux: registered CH-way, N-bit multiplexer with valid/ready output handshake.
// The channel is chosen either statically (MODE=0, via S) or by round-robin arbitration
// over REQ (MODE=1). The output word is held until READY accepts it.
// Optional feature: define RR_ARB_MUX_PARITY_EN to register even parity of Y on PAR;
// when undefined PAR is tied low and no parity logic exists.
module rr_arb_mux #(
  parameter int N  = 4,
  parameter int CH = 4,
  localparam int SW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [CH*N-1:0] D,
  input  logic [CH-1:0]   REQ,
  input  logic            MODE,
  input  logic [SW-1:0]   S,
  input  logic            READY,
  output logic [N-1:0]    Y,
  output logic            VALID,
  output logic [CH-1:0]   GNT,
  output logic [SW-1:0]   CHN,
  output logic            PAR
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    y_q, y_d;
  logic [CH-1:0]   gnt_q, gnt_d;
  logic [SW-1:0]   chn_q, chn_d;
  logic [SW-1:0]   ptr_q, ptr_d;

  logic            eligible;
  logic [SW-1:0]   sel;
  logic [SW-1:0]   rr_idx;
  logic [N-1:0]    sel_data;
  logic            take;

  // Candidate channel and eligibility; the round-robin scan runs from the farthest
  // offset down so the nearest requester after PTR is the one left in sel.
  always_comb begin
    eligible = 1'b0;
    sel      = '0;
    rr_idx   = '0;
    if (!MODE) begin
      for (int k = 0; k < CH; k++) begin
        if (S == SW'(k) && REQ[k]) begin
          eligible = 1'b1;
          sel      = SW'(k);
        end
      end
    end else begin
      for (int i = CH; i >= 1; i--) begin
        rr_idx = SW'((int'(ptr_q) + i) % CH);
        if (REQ[rr_idx]) begin
          eligible = 1'b1;
          sel      = rr_idx;
        end
      end
    end
  end

  // Data of the candidate channel
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < CH; k++) begin
      if (sel == SW'(k)) sel_data = D[k*N +: N];
    end
  end

  // A new decision is only made when the output register is free or being drained
  assign take = (state_q == IDLE) || READY;

  // Next-state logic: load on an eligible request, otherwise drop to IDLE when drained
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    gnt_d   = gnt_q;
    chn_d   = chn_q;
    ptr_d   = ptr_q;
    if (take) begin
      if (eligible) begin
        state_d = SEND;
        y_d     = sel_data;
        gnt_d   = CH'(1) << sel;
        chn_d   = sel;
        if (MODE) ptr_d = sel;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    end
  end

  // State and output registers; PTR resets to the last channel so channel 0 wins first
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      y_q     <= '0;
      gnt_q   <= '0;
      chn_q   <= '0;
      ptr_q   <= SW'(CH - 1);
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      gnt_q   <= gnt_d;
      chn_q   <= chn_d;
      ptr_q   <= ptr_d;
    end
  end

  assign Y     = y_q;
  assign VALID = (state_q == SEND);
  assign GNT   = gnt_q;
  assign CHN   = chn_q;

`ifdef RR_ARB_MUX_PARITY_EN
  logic par_q, par_d;

  // Parity is captured alongside Y and held with it
  always_comb begin
    par_d = par_q;
    if (take && eligible) par_d = ^sel_data;
  end

  // Parity register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) par_q <= 1'b0;
    else       par_q <= par_d;
  end

  assign PAR = par_q;
`else
  assign PAR = 1'b0;
`endif

endmodule
